// File: rtl/text_console_writer_pkg.sv
// Shared text-console geometry, control codes and FSM encoding for the
// character-RAM writer and the display side.
package text_console_writer_pkg;

  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 12;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// ASCII input stream: valid/ready handshake carrying one 8-bit code.
interface text_console_writer_if;
  logic       in_valid;
  logic [7:0] in_ascii;
  logic       in_ready;

  modport master (output in_valid, output in_ascii, input in_ready);
  modport slave  (input in_valid, input in_ascii, output in_ready);
endinterface

// File: rtl/text_console_writer_cursor.sv
// Row/column cursor with wrap rules; the linear address is registered alongside
// the counters so it changes on the same edge as row/col.
module text_cursor #(
  parameter int COLS   = text_console_writer_pkg::COLS,
  parameter int ROWS   = text_console_writer_pkg::ROWS,
  parameter int ADDR_W = text_console_writer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_advance,
  input  logic              i_retreat,
  input  logic              i_newline,
  input  logic              i_home,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0]     r_col, w_col_n;
  logic [RW-1:0]     r_row, w_row_n;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_n;

  always_comb begin
    w_col_n = r_col;
    w_row_n = r_row;
    if (i_home) begin
      w_col_n = '0;
      w_row_n = '0;
    end else if (i_advance) begin
      if (r_col == CW'(COLS - 1)) begin
        w_col_n = '0;
        w_row_n = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
      end else begin
        w_col_n = r_col + CW'(1);
      end
    end else if (i_newline) begin
      w_col_n = '0;
      w_row_n = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
    end else if (i_retreat) begin
      // Retreat from cell 0 is a no-op; otherwise cross into the previous row.
      if (r_col != '0) begin
        w_col_n = r_col - CW'(1);
      end else if (r_row != '0) begin
        w_col_n = CW'(COLS - 1);
        w_row_n = r_row - RW'(1);
      end else begin
        w_col_n = r_col;
      end
    end else begin
      w_col_n = r_col;
    end
    w_addr_n = ADDR_W'(w_row_n) * ADDR_W'(COLS) + ADDR_W'(w_col_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else begin
      r_col  <= w_col_n;
      r_row  <= w_row_n;
      r_addr <= w_addr_n;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/text_console_writer.sv
// Writer for the text-mode character RAM port B: clears the screen, then
// applies accepted ASCII codes (printable, CR/LF, BS, FF) at the cursor.
module text_console_writer #(
  parameter int COLS   = text_console_writer_pkg::COLS,
  parameter int ROWS   = text_console_writer_pkg::ROWS,
  parameter int ADDR_W = text_console_writer_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  text_console_writer_if.slave  i_stream,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_wren,
  output logic [ADDR_W-1:0]     cursor,
  output logic                  busy
);

  import text_console_writer_pkg::*;

  localparam int N_CELLS = COLS * ROWS;
  localparam int SW_W    = ADDR_W + 1;

  state_t            r_state;
  logic [SW_W-1:0]   r_sweep;
  logic [7:0]        r_code;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_data;
  logic              r_ram_wren;
  logic              r_ready;
  logic              r_busy;

  logic              w_adv, w_ret, w_nl, w_home;
  logic [ADDR_W-1:0] w_cursor;

  // Cursor motion is applied on the EXEC->IDLE edge from the latched code.
  always_comb begin
    w_adv  = 1'b0;
    w_ret  = 1'b0;
    w_nl   = 1'b0;
    w_home = 1'b0;
    if (r_state == ST_EXEC) begin
      if (is_printable(r_code)) begin
        w_adv = 1'b1;
      end else if ((r_code == ASCII_CR) || (r_code == ASCII_LF)) begin
        w_nl = 1'b1;
      end else if (r_code == ASCII_BS) begin
        w_ret = 1'b1;
      end else if (r_code == ASCII_FF) begin
        w_home = 1'b1;
      end else begin
        w_home = 1'b0;
      end
    end else begin
      w_adv = 1'b0;
    end
  end

  text_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .i_advance (w_adv),
    .i_retreat (w_ret),
    .i_newline (w_nl),
    .i_home    (w_home),
    .o_addr    (w_cursor)
  );

  // Main FSM; the RAM write is registered at acceptance so it appears in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_sweep    <= '0;
      r_code     <= 8'h00;
      r_ram_addr <= '0;
      r_ram_data <= 8'h00;
      r_ram_wren <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_ram_data <= 8'h00;
          if (r_sweep == SW_W'(N_CELLS)) begin
            r_state    <= ST_IDLE;
            r_ram_wren <= 1'b0;
            r_ram_addr <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_ram_wren <= 1'b1;
            r_ram_addr <= r_sweep[ADDR_W-1:0];
            r_sweep    <= r_sweep + SW_W'(1);
          end
        end
        ST_IDLE: begin
          if (i_stream.in_valid && r_ready) begin
            r_code  <= i_stream.in_ascii;
            r_state <= ST_EXEC;
            r_ready <= 1'b0;
            if (is_printable(i_stream.in_ascii)) begin
              r_ram_wren <= 1'b1;
              r_ram_addr <= w_cursor;
              r_ram_data <= i_stream.in_ascii;
            end else if ((i_stream.in_ascii == ASCII_BS) && (w_cursor != '0)) begin
              r_ram_wren <= 1'b1;
              r_ram_addr <= w_cursor - ADDR_W'(1);
              r_ram_data <= 8'h00;
            end else begin
              r_ram_wren <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          r_ram_wren <= 1'b0;
          r_ram_addr <= '0;
          r_ram_data <= 8'h00;
          if (r_code == ASCII_FF) begin
            r_state <= ST_CLEAR;
            r_sweep <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_sweep    <= '0;
          r_ram_wren <= 1'b0;
          r_ready    <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  assign i_stream.in_ready = r_ready;
  assign ram_addr          = r_ram_addr;
  assign ram_data          = r_ram_data;
  assign ram_wren          = r_ram_wren;
  assign cursor            = w_cursor;
  assign busy              = r_busy;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: clear sweep, printable wrap,
// CR/LF, backspace, form feed with held valid, and reset mid-sweep.
module tb_text_console_writer;

  logic        clk;
  logic        reset;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [11:0] cursor;
  logic        busy;
  int          n_cmp;
  int          n_err;

  text_console_writer_if bus ();

  text_console_writer dut (
    .clk      (clk),
    .reset    (reset),
    .i_stream (bus),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .cursor   (cursor),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge just after the clear starts; ends at the first IDLE negedge.
  task automatic sweep_check(input string tag);
    int idx;
    int bad;
    idx = 0;
    bad = 0;
    for (int k = 0; k < 10 && !ram_wren; k++) @(negedge clk);
    while (ram_wren && idx < 3000) begin
      if (ram_addr != idx[11:0] || ram_data != 8'h00 || busy != 1'b1 || bus.in_ready != 1'b0)
        bad++;
      idx++;
      @(negedge clk);
    end
    chk({tag, "_len"}, idx, 2100);
    chk({tag, "_bad"}, bad, 0);
    chk({tag, "_ready"}, bus.in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cursor"}, cursor, 0);
  endtask

  task automatic put(input logic [7:0] code);
    bus.in_valid = 1'b1;
    bus.in_ascii = code;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_chk(input string tag, input logic [7:0] code, input logic exp_wren,
                          input int exp_addr, input int exp_data, input int exp_cursor);
    chk({tag, "_rdy0"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_ascii = code;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_exec_rdy"}, bus.in_ready, 0);
    chk({tag, "_wren"}, ram_wren, exp_wren);
    if (exp_wren) begin
      chk({tag, "_addr"}, ram_addr, exp_addr);
      chk({tag, "_data"}, ram_data, exp_data);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy1"}, bus.in_ready, 1);
    chk({tag, "_wren_off"}, ram_wren, 0);
    chk({tag, "_cursor"}, cursor, exp_cursor);
  endtask

  initial begin
    int found;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_ascii = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;
    sweep_check("sweep0");

    send_chk("A", 8'h41, 1'b1, 0, 8'h41, 1);
    send_chk("B", 8'h42, 1'b1, 1, 8'h42, 2);
    for (int i = 0; i < 67; i++) put(8'h78);
    send_chk("Z", 8'h5A, 1'b1, 69, 8'h5A, 70);
    send_chk("bs70", 8'h08, 1'b1, 69, 8'h00, 69);
    for (int i = 0; i < 6; i++) put(8'h78);
    send_chk("cr75", 8'h0D, 1'b0, 0, 0, 140);
    for (int i = 0; i < 27; i++) put(8'h0A);
    chk("row29", cursor, 2030);
    send_chk("lf29", 8'h0A, 1'b0, 0, 0, 0);
    send_chk("bs0", 8'h08, 1'b0, 0, 0, 0);
    send_chk("ign", 8'h01, 1'b0, 0, 0, 0);
    for (int i = 0; i < 29; i++) put(8'h0A);
    for (int i = 0; i < 69; i++) put(8'h78);
    chk("at2099", cursor, 2099);
    send_chk("Q", 8'h51, 1'b1, 2099, 8'h51, 0);

    put(8'h41);
    chk("pre_ff", cursor, 1);
    bus.in_valid = 1'b1;
    bus.in_ascii = 8'h0C;
    @(posedge clk);
    @(negedge clk);
    chk("ff_exec_rdy", bus.in_ready, 0);
    chk("ff_exec_wren", ram_wren, 0);
    bus.in_ascii = 8'h43;
    sweep_check("sweep_ff");
    @(posedge clk);
    @(negedge clk);
    chk("C_wren", ram_wren, 1);
    chk("C_addr", ram_addr, 0);
    chk("C_data", ram_data, 8'h43);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("C_cursor", cursor, 1);

    put(8'h0C);
    found = 0;
    for (int k = 0; k < 1500 && found == 0; k++) begin
      if (ram_wren && ram_addr == 12'd1000) found = 1;
      else @(negedge clk);
    end
    chk("found1000", found, 1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst2_wren", ram_wren, 0);
    chk("rst2_addr", ram_addr, 0);
    chk("rst2_busy", busy, 1);
    chk("rst2_ready", bus.in_ready, 0);
    reset = 1'b0;
    sweep_check("sweep_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
